// File: rtl/header_loader_pkg.sv
// Shared definitions for the header loader front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package header_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_HEADER_BYTES = 12;
  localparam int NUM_TARGET_BYTES = 2;
  localparam int NONCE_WIDTH      = 32;
  localparam int WD_WIDTH         = 20;

endpackage

// File: rtl/header_loader_if.sv
// Host-side bundle: byte-stream input plus result return channel.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready throttles the byte stream; res_ready holds the result.
// Ports: master = host (drives bytes, flush, res_ready); slave = loader.
interface header_loader_if;
  import header_loader_pkg::*;

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   flush;
  logic                   res_valid;
  logic                   res_ready;
  logic [NONCE_WIDTH-1:0] res_nonce;
  logic                   res_fail;

  modport master (
    output in_valid, in_data, flush, res_ready,
    input  in_ready, res_valid, res_nonce, res_fail
  );

  modport slave (
    input  in_valid, in_data, flush, res_ready,
    output in_ready, res_valid, res_nonce, res_fail
  );

endinterface

// File: rtl/header_loader_watchdog_timer.sv
// Free-running search watchdog with synchronous clear and count enable.
// Latency: count updates one cycle after enable; expired is combinational on count.
// Backpressure: none.
// Ports: clk/reset, clear, enable in; count (20 bit) and expired out.
module header_loader_watchdog_timer
  import header_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  output logic [WD_WIDTH-1:0] count,
  output logic                expired
);

  localparam logic [WD_WIDTH-1:0] LAST_COUNT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/header_loader.sv
// Loads header+target bytes for the nonce core, runs it, and returns nonce or timeout.
// Latency: start rises 1 cycle after the last byte; result 1 cycle after finish/expiry.
// Backpressure: in_ready low outside LOAD; result held in DONE until res_ready.
// Ports: clk/reset; host (slave modport); block0..11/target/start to core;
//        core_finish/core_nonce0..3 from core.
module header_loader
  import header_loader_pkg::*;
#(
  parameter int HEADER_BYTES   = NUM_HEADER_BYTES,
  parameter int TARGET_BYTES   = NUM_TARGET_BYTES,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  header_loader_if.slave    host,
  output logic [7:0]        block0,
  output logic [7:0]        block1,
  output logic [7:0]        block2,
  output logic [7:0]        block3,
  output logic [7:0]        block4,
  output logic [7:0]        block5,
  output logic [7:0]        block6,
  output logic [7:0]        block7,
  output logic [7:0]        block8,
  output logic [7:0]        block9,
  output logic [7:0]        block10,
  output logic [7:0]        block11,
  output logic [15:0]       target,
  output logic              start,
  input  logic              core_finish,
  input  logic [7:0]        core_nonce0,
  input  logic [7:0]        core_nonce1,
  input  logic [7:0]        core_nonce2,
  input  logic [7:0]        core_nonce3
);

  localparam logic [3:0] TGT_HI_IDX = 4'(HEADER_BYTES);
  localparam logic [3:0] LAST_IDX   = 4'(HEADER_BYTES + TARGET_BYTES - 1);

  state_t              state, state_nx;
  logic [3:0]          byte_cnt;
  logic [7:0]          hdr [HEADER_BYTES];
  logic                transfer, capture_ok, capture_fail, res_hs;
  logic [WD_WIDTH-1:0] wd_count;
  logic                wd_expired;

  // Cleared throughout LOAD/DONE so the first RUN cycle always sees count 0.
  header_loader_watchdog_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_RUN),
    .enable  (state == ST_RUN),
    .count   (wd_count),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    transfer     = 1'b0;
    capture_ok   = 1'b0;
    capture_fail = 1'b0;
    res_hs       = 1'b0;
    case (state)
      ST_LOAD: begin
        // flush drops any byte offered in the same cycle
        transfer = host.in_valid & host.in_ready & ~host.flush;
        if (transfer && byte_cnt == LAST_IDX) state_nx = ST_RUN;
      end
      ST_RUN: begin
        // count 0 marks the core's start-latch cycle, where finish is stale;
        // finish is checked before expiry so it wins a tie
        if (core_finish && wd_count != '0) begin
          capture_ok = 1'b1;
          state_nx   = ST_DONE;
        end else if (wd_expired) begin
          capture_fail = 1'b1;
          state_nx     = ST_DONE;
        end
      end
      ST_DONE: begin
        res_hs = host.res_valid & host.res_ready;
        if (res_hs) state_nx = ST_LOAD;
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt       <= '0;
      target         <= '0;
      start          <= 1'b0;
      host.in_ready  <= 1'b0;
      host.res_valid <= 1'b0;
      host.res_fail  <= 1'b0;
      host.res_nonce <= '0;
      for (int i = 0; i < HEADER_BYTES; i++) hdr[i] <= '0;
    end else begin
      // start stays high through DONE so the core keeps its outputs until the host takes them
      host.in_ready <= (state_nx == ST_LOAD);
      start         <= (state_nx != ST_LOAD);

      if (state == ST_LOAD && host.flush) begin
        byte_cnt <= '0;
      end else if (transfer) begin
        byte_cnt <= (byte_cnt == LAST_IDX) ? 4'd0 : byte_cnt + 4'd1;
      end else if (res_hs) begin
        byte_cnt <= '0;
      end

      if (transfer) begin
        if (byte_cnt < TGT_HI_IDX)       hdr[byte_cnt] <= host.in_data;
        else if (byte_cnt == TGT_HI_IDX) target[15:8]  <= host.in_data;
        else                             target[7:0]   <= host.in_data;
      end

      if (capture_ok) begin
        host.res_valid <= 1'b1;
        host.res_fail  <= 1'b0;
        host.res_nonce <= {core_nonce0, core_nonce1, core_nonce2, core_nonce3};
      end else if (capture_fail) begin
        host.res_valid <= 1'b1;
        host.res_fail  <= 1'b1;
        host.res_nonce <= '0;
      end else if (res_hs) begin
        host.res_valid <= 1'b0;
      end
    end
  end

  assign block0  = hdr[0];
  assign block1  = hdr[1];
  assign block2  = hdr[2];
  assign block3  = hdr[3];
  assign block4  = hdr[4];
  assign block5  = hdr[5];
  assign block6  = hdr[6];
  assign block7  = hdr[7];
  assign block8  = hdr[8];
  assign block9  = hdr[9];
  assign block10 = hdr[10];
  assign block11 = hdr[11];

endmodule

// File: tb/tb_header_loader.sv
// Self-checking bench for header_loader with a result scoreboard and header model.
module tb_header_loader;

  typedef struct packed {
    logic [31:0] nonce;
    logic        fail;
  } res_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [11:0][7:0] blk;
  logic [15:0]      target;
  logic             start;
  logic             core_finish;
  logic [7:0]       n0, n1, n2, n3;

  header_loader_if hif ();

  header_loader #(.TIMEOUT_CYCLES(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (hif.slave),
    .block0      (blk[0]),
    .block1      (blk[1]),
    .block2      (blk[2]),
    .block3      (blk[3]),
    .block4      (blk[4]),
    .block5      (blk[5]),
    .block6      (blk[6]),
    .block7      (blk[7]),
    .block8      (blk[8]),
    .block9      (blk[9]),
    .block10     (blk[10]),
    .block11     (blk[11]),
    .target      (target),
    .start       (start),
    .core_finish (core_finish),
    .core_nonce0 (n0),
    .core_nonce1 (n1),
    .core_nonce2 (n2),
    .core_nonce3 (n3)
  );

  always #5 clk = ~clk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  res_t exp_q[$];

  // header model: what the loader should hold after the bytes actually accepted
  logic [7:0]  m_hdr [12];
  logic [15:0] m_tgt;
  int          m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_put(input logic [7:0] b);
    if (m_cnt < 12)       m_hdr[m_cnt] = b;
    else if (m_cnt == 12) m_tgt[15:8]  = b;
    else                  m_tgt[7:0]   = b;
    m_cnt = (m_cnt == 13) ? 0 : m_cnt + 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    hif.in_valid = 1'b1;
    hif.in_data  = b;
    while (hif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", hif.in_ready);
    end else begin
      tick();
      model_put(b);
    end
  endtask

  task automatic wait_result();
    int   n = 0;
    res_t e;
    while (hif.res_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n >= 100 || exp_q.size() == 0) begin
      $display("FAIL wait_result: res_valid=%b queued=%0d", hif.res_valid, exp_q.size());
    end else begin
      pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (hif.res_nonce !== e.nonce)
        $display("FAIL res_nonce: got %h required %h", hif.res_nonce, e.nonce);
      else pass_cnt++;
      total_cnt++;
      if (hif.res_fail !== e.fail)
        $display("FAIL res_fail: got %b required %b", hif.res_fail, e.fail);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({hif.in_ready, start, hif.res_valid, hif.res_fail} !== 4'b0000)
      $display("FAIL reset_ctrl: rdy/start/vld/fail=%b required 0000",
               {hif.in_ready, start, hif.res_valid, hif.res_fail});
    else pass_cnt++;
    total_cnt++;
    if ({blk, target, hif.res_nonce} !== '0)
      $display("FAIL reset_data: blk=%h tgt=%h nonce=%h required 0", blk, target, hif.res_nonce);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (hif.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", hif.in_ready);
    else pass_cnt++;
  endtask

  task automatic check_blocks(input string tag);
    for (int i = 0; i < 12; i++) begin
      total_cnt++;
      if (blk[i] !== m_hdr[i])
        $display("FAIL %s_block%0d: got %h required %h", tag, i, blk[i], m_hdr[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 12; i++) send_byte(8'(i + 1));
    send_byte(8'h00);
    total_cnt++;
    if (start !== 1'b0) $display("FAIL load_start_early: got %b required 0", start);
    else pass_cnt++;
    send_byte(8'h0A);
    hif.in_valid = 1'b0;
    total_cnt++;
    if (start !== 1'b1 || hif.in_ready !== 1'b0)
      $display("FAIL load_start: start=%b in_ready=%b required 1/0", start, hif.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (target !== 16'h000A) $display("FAIL load_target: got %h required 000a", target);
    else pass_cnt++;
    check_blocks("load");
  endtask

  task automatic test_finish();
    // junk on the byte port and flush during RUN must not disturb anything
    hif.in_valid = 1'b1;
    hif.in_data  = 8'hFF;
    hif.flush    = 1'b1;
    // first RUN cycle: finish must be ignored
    {n0, n1, n2, n3} = 32'h11223344;
    core_finish = 1'b1;
    tick();
    core_finish = 1'b0;
    total_cnt++;
    if (hif.res_valid !== 1'b0) $display("FAIL finish_first_cycle: res_valid=%b required 0", hif.res_valid);
    else pass_cnt++;
    tick();
    {n0, n1, n2, n3} = 32'hDEADBEEF;
    core_finish = 1'b1;
    exp_q.push_back('{nonce: 32'hDEADBEEF, fail: 1'b0});
    tick();
    core_finish = 1'b0;
    {n0, n1, n2, n3} = 32'h0;
    wait_result();
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++;
      if (hif.res_valid !== 1'b1 || start !== 1'b1 || hif.res_nonce !== 32'hDEADBEEF || hif.res_fail !== 1'b0)
        $display("FAIL done_hold%0d: vld=%b start=%b nonce=%h fail=%b required 1/1/deadbeef/0",
                 c, hif.res_valid, start, hif.res_nonce, hif.res_fail);
      else pass_cnt++;
    end
    check_blocks("frozen");
    total_cnt++;
    if (target !== 16'h000A) $display("FAIL frozen_target: got %h required 000a", target);
    else pass_cnt++;
    hif.in_valid  = 1'b0;
    hif.flush     = 1'b0;
    hif.res_ready = 1'b1;
    tick();
    hif.res_ready = 1'b0;
    total_cnt++;
    if (hif.res_valid !== 1'b0 || start !== 1'b0 || hif.in_ready !== 1'b1)
      $display("FAIL handshake: vld=%b start=%b in_ready=%b required 0/0/1",
               hif.res_valid, start, hif.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n = 0;
    for (int i = 0; i < 14; i++) send_byte(8'(8'h30 + i));
    hif.in_valid = 1'b0;
    exp_q.push_back('{nonce: 32'h0, fail: 1'b1});
    while (hif.res_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 20) $display("FAIL timeout_cycles: result after %0d cycles required 20", n);
    else pass_cnt++;
    wait_result();
    hif.res_ready = 1'b1;
    tick();
    hif.res_ready = 1'b0;
  endtask

  task automatic test_tie();
    for (int i = 0; i < 14; i++) send_byte(8'(8'h60 + i));
    hif.in_valid = 1'b0;
    for (int c = 0; c < 19; c++) tick();
    total_cnt++;
    if (hif.res_valid !== 1'b0) $display("FAIL tie_early: res_valid=%b required 0", hif.res_valid);
    else pass_cnt++;
    {n0, n1, n2, n3} = 32'h12345678;
    core_finish = 1'b1;
    exp_q.push_back('{nonce: 32'h12345678, fail: 1'b0});
    tick();
    core_finish = 1'b0;
    total_cnt++;
    if (hif.res_valid !== 1'b1) $display("FAIL tie_valid: res_valid=%b required 1", hif.res_valid);
    else pass_cnt++;
    wait_result();
    hif.res_ready = 1'b1;
    tick();
    hif.res_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i));
    hif.in_valid = 1'b1;
    hif.in_data  = 8'h99;
    hif.flush    = 1'b1;
    tick();
    hif.flush = 1'b0;
    m_cnt     = 0;
    for (int i = 0; i < 13; i++) send_byte(8'(8'hA0 + i));
    total_cnt++;
    if (start !== 1'b0) $display("FAIL flush_start_early: got %b required 0", start);
    else pass_cnt++;
    send_byte(8'hAD);
    hif.in_valid = 1'b0;
    total_cnt++;
    if (start !== 1'b1 || blk[0] !== 8'hA0 || target !== 16'hACAD)
      $display("FAIL flush_reload: start=%b block0=%h target=%h required 1/a0/acad", start, blk[0], target);
    else pass_cnt++;
    check_blocks("flush");
  endtask

  task automatic test_reset_in_run();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) m_hdr[i] = 8'h00;
    m_cnt = 0;
    total_cnt++;
    if (start !== 1'b0 || hif.res_valid !== 1'b0 || target !== 16'h0 || hif.in_ready !== 1'b0)
      $display("FAIL run_reset: start=%b vld=%b target=%h in_ready=%b required 0/0/0000/0",
               start, hif.res_valid, target, hif.in_ready);
    else pass_cnt++;
    check_blocks("run_reset");
    tick();
    total_cnt++;
    if (hif.in_ready !== 1'b1) $display("FAIL run_reset_ready: got %b required 1", hif.in_ready);
    else pass_cnt++;
    for (int c = 0; c < 25; c++) tick();
    total_cnt++;
    if (hif.res_valid !== 1'b0 || start !== 1'b0)
      $display("FAIL run_reset_quiet: vld=%b start=%b required 0/0", hif.res_valid, start);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] nonce;
    hif.res_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 14; i++) send_byte(8'($urandom_range(0, 255)));
      hif.in_valid = 1'b0;
      for (int c = 0; c < 2 + t; c++) tick();
      nonce = $urandom;
      {n0, n1, n2, n3} = nonce;
      core_finish = 1'b1;
      exp_q.push_back('{nonce: nonce, fail: 1'b0});
      tick();
      core_finish = 1'b0;
      wait_result();
      check_blocks("b2b");
      total_cnt++;
      if (target !== m_tgt) $display("FAIL b2b_target: got %h required %h", target, m_tgt);
      else pass_cnt++;
      tick();
    end
    hif.res_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    hif.in_valid  = 1'b0;
    hif.in_data   = 8'h00;
    hif.flush     = 1'b0;
    hif.res_ready = 1'b0;
    core_finish   = 1'b0;
    {n0, n1, n2, n3} = 32'h0;
    m_cnt = 0;
    m_tgt = 16'h0;
    for (int i = 0; i < 12; i++) m_hdr[i] = 8'h00;

    test_reset();
    test_load();
    test_finish();
    test_timeout();
    test_tie();
    test_flush();
    test_reset_in_run();
    test_back_to_back();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
